// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM states,
// character-length decode and the receive FIFO entry layout.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam int DATA_W  = 8;
    // Entry layout: {break, framing error, parity error, data[7:0]}
    localparam int ENTRY_W = 11;

    function automatic logic [3:0] len_bits(input logic [1:0] len);
        logic [3:0] n;
        case (len)
            LEN_5:   n = 4'd5;
            LEN_6:   n = 4'd6;
            LEN_7:   n = 4'd7;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with wrapping pointers, occupancy count and a sticky
// overflow flag; the head entry is read combinationally.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same clk frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full && !do_pop) overflow <= 1'b1;
            else if (ovf_clr)            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote filter, configurable frame
// format, break detection and a small receive FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          baud_clock,
    input  logic                          rx,
    input  logic [1:0]                    cfg_len,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          cfg_stop2,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_err,
    output logic                          framing_err,
    output logic                          break_det,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_idle
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    rx_state_t          state;
    rx_state_t          state_nx;
    logic               sync1;
    logic               sync2;
    logic [2:0]         filt3;
    logic               filt;
    logic [CW-1:0]      cnt;
    logic [2:0]         bitn;
    logic               pend;
    logic               brk_hold;
    logic [1:0]         len_l;
    logic               par_en_l;
    logic               par_odd_l;
    logic               stop2_l;
    logic [DATA_W-1:0]  data_sh;
    logic               par_acc;
    logic               any_one;
    logic               perr;
    logic               ferr;
    logic               brk;
    logic               last_data;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               latch;
    logic               smp;
    logic               fin;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Input conditioning: two-flop synchroniser, then 3-tap majority vote.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt3 <= 3'b111;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            if (baud_clock) filt3 <= {filt3[1:0], sync2};
        end
    end

    assign filt = (filt3[0] & filt3[1]) | (filt3[0] & filt3[2]) | (filt3[1] & filt3[2]);
    assign last_data = ({1'b0, bitn} == (len_bits(len_l) - 4'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Frame sequencing: mid-bit start check, then full-bit sample points.
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        latch    = 1'b0;
        smp      = 1'b0;
        fin      = 1'b0;
        push     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (baud_clock && !brk_hold && !filt) begin
                    state_nx = ST_START;
                    cnt_clr  = 1'b1;
                end
            end
            ST_START: begin
                if (baud_clock) begin
                    if (cnt == HALF_M1) begin
                        cnt_clr = 1'b1;
                        if (!filt) begin
                            state_nx = ST_DATA;
                            latch    = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                // The completed entry is written one clk after the last stop sample.
                if (pend) begin
                    push     = 1'b1;
                    state_nx = ST_IDLE;
                end else if (baud_clock) begin
                    if (cnt == FULL_M1) begin
                        smp     = 1'b1;
                        cnt_clr = 1'b1;
                        case (state)
                            ST_DATA:   if (last_data) state_nx = par_en_l ? ST_PARITY : ST_STOP1;
                            ST_PARITY: state_nx = ST_STOP1;
                            ST_STOP1:  if (stop2_l) state_nx = ST_STOP2;
                                       else         fin = 1'b1;
                            default:   fin = 1'b1;
                        endcase
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            bitn      <= '0;
            pend      <= 1'b0;
            brk_hold  <= 1'b0;
            len_l     <= LEN_8;
            par_en_l  <= 1'b0;
            par_odd_l <= 1'b0;
            stop2_l   <= 1'b0;
            data_sh   <= '0;
            par_acc   <= 1'b0;
            any_one   <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            brk       <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CW'(1);

            if (push)     pend <= 1'b0;
            else if (fin) pend <= 1'b1;

            // After a break, wait for the line to go idle before hunting for a start bit.
            if (push && brk)                             brk_hold <= 1'b1;
            else if (rx_idle && baud_clock && filt)      brk_hold <= 1'b0;

            if (latch) begin
                len_l     <= cfg_len;
                par_en_l  <= cfg_par_en;
                par_odd_l <= cfg_par_odd;
                stop2_l   <= cfg_stop2;
                data_sh   <= '0;
                par_acc   <= 1'b0;
                any_one   <= 1'b0;
                bitn      <= '0;
                perr      <= 1'b0;
                ferr      <= 1'b0;
                brk       <= 1'b0;
            end else if (smp) begin
                case (state)
                    ST_DATA: begin
                        data_sh[bitn] <= filt;
                        par_acc       <= par_acc ^ filt;
                        any_one       <= any_one | filt;
                        bitn          <= bitn + 3'd1;
                    end
                    ST_PARITY: begin
                        perr    <= filt ^ par_acc ^ par_odd_l;
                        any_one <= any_one | filt;
                    end
                    ST_STOP1: begin
                        ferr <= ferr | ~filt;
                        brk  <= ~any_one & ~filt;
                    end
                    default: ferr <= ferr | ~filt;
                endcase
            end
        end
    end

    // Receive FIFO and head-entry presentation.
    assign pop = rx_valid & rx_ready;

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .wdata    ({brk, ferr, perr, data_sh}),
        .pop      (pop),
        .ovf_clr  (ovf_clr),
        .rdata    (head),
        .count    (rx_count),
        .overflow (overflow)
    );

    assign rx_valid    = (rx_count != '0);
    assign rx_data     = rx_valid ? head[7:0] : 8'h00;
    assign parity_err  = rx_valid & head[8];
    assign framing_err = rx_valid & head[9];
    assign break_det   = rx_valid & head[10];
    assign rx_idle     = (state == ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed frames plus randomized frames checked
// against a frame-level reference model and FIFO queue.
module tb_uart_rx_param;

    localparam int OS    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             baud_clock = 1'b0;
    logic             rx = 1'b1;
    logic [1:0]       cfg_len = 2'b11;
    logic             cfg_par_en = 1'b0;
    logic             cfg_par_odd = 1'b0;
    logic             cfg_stop2 = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready = 1'b0;
    logic             parity_err;
    logic             framing_err;
    logic             break_det;
    logic             overflow;
    logic             ovf_clr = 1'b0;
    logic [CNT_W-1:0] rx_count;
    logic             rx_idle;

    int               vectors = 0;
    int               miscompares = 0;
    logic [10:0]      exp_q[$];
    logic             exp_ovf = 1'b0;
    logic             div = 1'b0;

    uart_rx_param #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_clock  (baud_clock),
        .rx          (rx),
        .cfg_len     (cfg_len),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .break_det   (break_det),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .rx_count    (rx_count),
        .rx_idle     (rx_idle)
    );

    always #5 clk = ~clk;

    // One-clk sample tick every second clk.
    always @(posedge clk) begin
        div        <= ~div;
        baud_clock <= div;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (baud_clock !== 1'b1) @(negedge clk);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        tick_wait(n);
    endtask

    // A zero stop bit returns high early so the line is idle soon after the frame.
    task automatic stop_bit(input logic v);
        if (v) drive(1'b1, OS);
        else begin
            drive(1'b0, OS/2 + 4);
            drive(1'b1, OS/2 - 4);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] len, input logic pen,
                              input logic podd, input logic st2, input logic flip,
                              input logic s1, input logic s2, input logic scramble);
        int          nb;
        logic [7:0]  dm;
        logic        par;
        logic [10:0] e;
        nb  = int'(len) + 5;
        dm  = d & 8'((1 << nb) - 1);
        par = (^dm) ^ podd ^ flip;
        cfg_len = len; cfg_par_en = pen; cfg_par_odd = podd; cfg_stop2 = st2;
        drive(1'b0, OS);
        for (int i = 0; i < nb; i++) begin
            drive(dm[i], OS);
            if (i == 0 && scramble) begin
                cfg_len = 2'($urandom); cfg_par_en = 1'($urandom);
                cfg_par_odd = 1'($urandom); cfg_stop2 = 1'($urandom);
            end
        end
        if (pen) drive(par, OS);
        stop_bit(s1);
        if (st2) stop_bit(s2);
        drive(1'b1, 2*OS);
        e = {(dm == 8'h00) && (!pen || !par) && !s1,
             !s1 || (st2 && !s2),
             pen && (par != ((^dm) ^ podd)),
             dm};
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic pop_one();
        logic [10:0] dummy;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        if (exp_q.size() > 0) dummy = exp_q.pop_front();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_valid, rx_data, parity_err, framing_err, break_det, overflow} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", {rx_valid, rx_data, parity_err, framing_err, break_det, overflow});
        end
        vectors++;
        if (rx_count !== '0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", rx_count); end
        vectors++;
        if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got=%b want=1", rx_idle); end
        reset_n = 1'b1;
        tick_wait(4);
    endtask

    task automatic test_8n1();
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL 8n1_valid got=%b want=1", rx_valid); end
        vectors++;
        if ({break_det, framing_err, parity_err, rx_data} !== 11'h0A5) begin
            miscompares++;
            $display("FAIL 8n1_head got=%h want=0a5", {break_det, framing_err, parity_err, rx_data});
        end
        vectors++;
        if (rx_count !== CNT_W'(1)) begin miscompares++; $display("FAIL 8n1_count got=%0d want=1", rx_count); end
        pop_one();
        vectors++;
        if ({rx_valid, rx_count} !== '0) begin miscompares++; $display("FAIL 8n1_after_pop valid=%b count=%0d want 0/0", rx_valid, rx_count); end
    endtask

    task automatic test_7o1_parity();
        send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({break_det, framing_err, parity_err, rx_data} !== 11'h135) begin
            miscompares++;
            $display("FAIL 7o1_badpar got=%h want=135", {break_det, framing_err, parity_err, rx_data});
        end
        pop_one();
        send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({break_det, framing_err, parity_err, rx_data} !== 11'h035) begin
            miscompares++;
            $display("FAIL 7o1_goodpar got=%h want=035", {break_det, framing_err, parity_err, rx_data});
        end
        pop_one();
    endtask

    task automatic test_8n2_break();
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({break_det, framing_err, parity_err, rx_data} !== 11'h23C) begin
            miscompares++;
            $display("FAIL 8n2_ferr got=%h want=23c", {break_det, framing_err, parity_err, rx_data});
        end
        pop_one();
        drive(1'b0, 20*OS);
        drive(1'b1, 3*OS);
        exp_q.push_back(11'h600);
        vectors++;
        if (rx_count !== CNT_W'(1)) begin miscompares++; $display("FAIL break_count got=%0d want=1", rx_count); end
        vectors++;
        if ({break_det, framing_err, parity_err, rx_data} !== exp_q[0]) begin
            miscompares++;
            $display("FAIL break_head got=%h want=%h", {break_det, framing_err, parity_err, rx_data}, exp_q[0]);
        end
        pop_one();
        tick_wait(2*OS);
        vectors++;
        if (rx_count !== '0) begin miscompares++; $display("FAIL break_second_entry count=%0d want=0", rx_count); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (rx_count !== CNT_W'(exp_q.size())) begin miscompares++; $display("FAIL ovf_count got=%0d want=%0d", rx_count, exp_q.size()); end
        vectors++;
        if (overflow !== exp_ovf) begin miscompares++; $display("FAIL ovf_flag got=%b want=%b", overflow, exp_ovf); end
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if (rx_data !== 8'(k + 1) || exp_q[0][7:0] !== 8'(k + 1)) begin
                miscompares++;
                $display("FAIL ovf_pop%0d got=%h want=%h", k, rx_data, 8'(k + 1));
            end
            pop_one();
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got=%b want=0", overflow); end
    endtask

    task automatic test_glitch();
        drive(1'b0, 5);
        rx = 1'b1;
        tick_wait(1);
        vectors++;
        if (rx_idle !== 1'b0) begin miscompares++; $display("FAIL glitch_start got idle=%b want=0", rx_idle); end
        tick_wait(2*OS);
        vectors++;
        if (rx_idle !== 1'b1) begin miscompares++; $display("FAIL glitch_idle got=%b want=1", rx_idle); end
        vectors++;
        if (rx_count !== '0) begin miscompares++; $display("FAIL glitch_push count=%0d want=0", rx_count); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] partial;
        partial = 8'hC3;
        cfg_len = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
        drive(1'b0, OS);
        for (int i = 0; i < 3; i++) drive(partial[i], OS);
        reset_n = 1'b0;
        rx = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_idle, rx_count} !== {1'b1, CNT_W'(0)}) begin
            miscompares++;
            $display("FAIL midreset_state idle=%b count=%0d want 1/0", rx_idle, rx_count);
        end
        reset_n = 1'b1;
        drive(1'b1, 2*OS);
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({rx_count, rx_data} !== {CNT_W'(1), 8'h5A}) begin
            miscompares++;
            $display("FAIL midreset_frame count=%0d data=%h want 1/5a", rx_count, rx_data);
        end
        pop_one();
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int n = 0; n < 12; n++) begin
            d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            send_frame(d, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1'b1);
            vectors++;
            if (rx_count !== CNT_W'(exp_q.size()) || rx_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rand%0d_count got=%0d valid=%b want=%0d", n, rx_count, rx_valid, exp_q.size());
            end else begin
                vectors++;
                if ({break_det, framing_err, parity_err, rx_data} !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL rand%0d_head got=%h want=%h", n, {break_det, framing_err, parity_err, rx_data}, exp_q[0]);
                end
            end
            pop_one();
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++)
            send_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'b1, 1'b1, 1'b0);
        vectors++;
        if (rx_count !== CNT_W'(3)) begin miscompares++; $display("FAIL b2b_count got=%0d want=3", rx_count); end
        while (exp_q.size() > 0) begin
            vectors++;
            if ({break_det, framing_err, parity_err, rx_data} !== exp_q[0]) begin
                miscompares++;
                $display("FAIL b2b_head got=%h want=%h", {break_det, framing_err, parity_err, rx_data}, exp_q[0]);
            end
            pop_one();
        end
        vectors++;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain valid=%b want=0", rx_valid); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_7o1_parity();
        test_8n2_break();
        test_overflow();
        test_glitch();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
